// File: rtl/ccff_chain_loader.sv
// Serial configuration-chain writer: serializes bitstream words MSB-first
// into ccff_head and folds the bits leaving ccff_tail into a parity signature.
module ccff_chain_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 48,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              chain_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              tail_parity
);

    localparam int BL_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [BL_W-1:0]  FULL_BITS = BL_W'(WORD_W);
    localparam logic [BL_W-1:0]  ONE_BIT   = BL_W'(1);

    typedef enum logic {
        IDLE,
        LOAD
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [BL_W-1:0]   bits_left_q, bits_left_d;
    logic [CNT_W-1:0]  shift_cnt_q, shift_cnt_d;
    logic              acc_q, acc_d;
    logic              tail_parity_q, tail_parity_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              in_load;
    logic              shift_en;
    logic              ready;
    logic              accept;
    logic [31:0]       committed;

    // Handshake and shift controls depend on state registers only.
    always_comb begin
        in_load   = (state_q == LOAD);
        shift_en  = in_load && (bits_left_q != '0)
                    && (32'(shift_cnt_q) < 32'(CHAIN_LEN));
        committed = 32'(shift_cnt_q) + 32'(bits_left_q);
        ready     = in_load
                    && ((bits_left_q == '0)
                        || ((bits_left_q == ONE_BIT) && shift_en))
                    && (committed < 32'(CHAIN_LEN));
        accept    = s_valid && ready;
    end

    always_comb begin
        state_d       = state_q;
        sreg_d        = sreg_q;
        bits_left_d   = bits_left_q;
        shift_cnt_d   = shift_cnt_q;
        acc_d         = acc_q;
        tail_parity_d = tail_parity_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = LOAD;
                    shift_cnt_d = '0;
                    bits_left_d = '0;
                    acc_d       = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            LOAD: begin
                if (shift_en) begin
                    sreg_d      = {sreg_q[WORD_W-2:0], 1'b0};
                    bits_left_d = bits_left_q - ONE_BIT;
                    shift_cnt_d = shift_cnt_q + CNT_W'(1);
                    acc_d       = acc_q ^ ccff_tail;
                end
                if (accept) begin
                    sreg_d      = s_data;
                    bits_left_d = FULL_BITS;
                end
                // Any unshifted bits of the final word are dropped here.
                if (shift_en && (shift_cnt_q == LAST_CNT)) begin
                    state_d       = IDLE;
                    bits_left_d   = '0;
                    busy_d        = 1'b0;
                    done_d        = 1'b1;
                    tail_parity_d = acc_q ^ ccff_tail;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state_q       <= IDLE;
            sreg_q        <= '0;
            bits_left_q   <= '0;
            shift_cnt_q   <= '0;
            acc_q         <= 1'b0;
            tail_parity_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sreg_q        <= sreg_d;
            bits_left_q   <= bits_left_d;
            shift_cnt_q   <= shift_cnt_d;
            acc_q         <= acc_d;
            tail_parity_q <= tail_parity_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign s_ready        = ready;
    assign chain_shift_en = shift_en;
    assign ccff_head      = shift_en & sreg_q[WORD_W-1];
    assign busy           = busy_q;
    assign done           = done_q;
    assign tail_parity    = tail_parity_q;

endmodule
